sa_skew_feeder: RTL

SA_SKEW_FEEDER -- requirements
Module: SA_SKEW_FEEDER

---
 rtl/sa_skew_feeder_if.sv | 26 ++
 rtl/sa_skew_feeder.sv | 101 ++++++++++
 2 files changed

// File: rtl/sa_skew_feeder_if.sv
// Handshake and skewed-output bundle between a vector source, the skew feeder and
// the systolic array.
interface sa_skew_feeder_if #(
    parameter int ROWS   = 8,
    parameter int DATA_W = 8
);
    logic [ROWS*DATA_W-1:0] in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_last;
    logic                   adv;
    logic [ROWS*DATA_W-1:0] out_data;
    logic [ROWS-1:0]        out_valid;
    logic                   busy;
    logic                   tile_done;

    modport master (
        output in_data, in_valid, in_last, adv,
        input  in_ready, out_data, out_valid, busy, tile_done
    );

    modport slave (
        input  in_data, in_valid, in_last, adv,
        output in_ready, out_data, out_valid, busy, tile_done
    );
endinterface

// File: rtl/sa_skew_feeder.sv
// Skews an input vector across ROWS lanes (lane i delayed by i+1 advances) and tracks
// tile boundaries so tile_done fires once the last element reaches the last lane.
module sa_skew_feeder #(
    parameter int ROWS   = 8,
    parameter int DATA_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    sa_skew_feeder_if.slave  bus
);
    localparam int CntW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

    state_e                 r_state, w_state_nxt;
    logic [CntW-1:0]        r_cnt, w_cnt_nxt;
    logic                   r_tile_done, w_tile_done_nxt;
    logic                   w_ready;
    logic                   w_accept;
    logic [ROWS-1:0]        w_lane_vld;
    logic [ROWS*DATA_W-1:0] w_out_data;
    logic [ROWS-1:0]        w_out_valid;

    assign w_ready  = bus.adv & (r_state != StDrain);
    assign w_accept = bus.in_valid & w_ready;

    for (genvar i = 0; i < ROWS; i++) begin : g_lane
        logic [i:0][DATA_W-1:0] r_data;
        logic [i:0]             r_vld;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_data <= '0;
                r_vld  <= '0;
            end else if (bus.adv) begin
                // Stage 0 takes a bubble (zero data, invalid) on any advance without accept.
                r_data[0] <= w_accept ? bus.in_data[i*DATA_W +: DATA_W] : '0;
                r_vld[0]  <= w_accept;
                for (int j = 1; j <= i; j++) begin
                    r_data[j] <= r_data[j-1];
                    r_vld[j]  <= r_vld[j-1];
                end
            end
        end

        assign w_out_data[i*DATA_W +: DATA_W] = r_data[i];
        assign w_out_valid[i]                 = r_vld[i];
        assign w_lane_vld[i]                  = |r_vld;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_tile_done_nxt = 1'b0;
        if (bus.adv) begin
            case (r_state)
                StIdle, StStream: begin
                    if (w_accept) begin
                        if (!bus.in_last) begin
                            w_state_nxt = StStream;
                        end else if (ROWS == 1) begin
                            w_state_nxt     = StIdle;
                            w_tile_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt = StDrain;
                            w_cnt_nxt   = CntW'(ROWS - 1);
                        end
                    end
                end
                StDrain: begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    // Counter hits zero on the same advance the last lane loads the in_last element.
                    if (r_cnt == CntW'(1)) begin
                        w_state_nxt     = StIdle;
                        w_tile_done_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_tile_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            // Pulse is cleared on the following edge even under stall.
            r_tile_done <= w_tile_done_nxt;
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_data  = w_out_data;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = (r_state != StIdle) | (|w_lane_vld);
    assign bus.tile_done = r_tile_done;
endmodule
